// File: rtl/instruction_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instruction_fetch_buffer
//
// Fetch-side initiator for the instruction memory read port. Drives the fetch
// address, takes the combinational 32-bit window returned for it, extracts one
// 16- or 32-bit instruction per cycle and queues it with its PC for decode
// behind a valid/ready handshake.
//
// Parameters
//   XLEN          address / PC width (32 or 64)
//   RESET_VECTOR  fetch PC loaded on reset
//   FIFO_DEPTH    queue entries, power of two, >= 2
//   C_EXT         1: accept 16-bit compressed instructions, 0: 32-bit only
//
// Ports
//   clk             clock, all state updates on rising edge
//   reset           asynchronous, active-high reset
//   imem_addr       fetch byte address (= fetch PC)
//   imem_rdata      32-bit window read combinationally at imem_addr
//   redirect_valid  flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch PC, bit 0 forced to zero
//   out_valid       queue head valid
//   out_ready       decode accepts head when out_valid & out_ready
//   out_instr       head instruction, compressed ones as {16'h0, half}
//   out_pc          PC of head instruction
//   out_compressed  head is a 16-bit instruction
//   out_misaligned  head is an instruction-address-misaligned marker
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module instruction_fetch_buffer #(
    parameter int unsigned     XLEN         = `XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FIFO_DEPTH   = 2,
    parameter bit              C_EXT        = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_compressed,
    output logic            out_misaligned
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Fetch either runs freely or is parked after emitting a misaligned marker.
    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } fetch_state_t;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;

    // Circular queue storage
    logic [31:0]     q_instr [FIFO_DEPTH];
    logic [XLEN-1:0] q_pc    [FIFO_DEPTH];
    logic            q_comp  [FIFO_DEPTH];
    logic            q_mis   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic            pop;
    logic            is_full;
    logic            can_push;
    logic            misaligned_fetch;
    logic            is_compressed;
    logic [31:0]     push_instr;
    logic [XLEN-1:0] next_seq_pc;
    logic [XLEN-1:0] redirect_target;

    assign imem_addr = fetch_pc;

    // Head of the queue drives the decode side directly from registers.
    assign out_valid      = (count != '0);
    assign out_instr      = q_instr[rd_ptr];
    assign out_pc         = q_pc[rd_ptr];
    assign out_compressed = q_comp[rd_ptr];
    assign out_misaligned = q_mis[rd_ptr];

    always_comb begin
        pop              = out_valid & out_ready;
        is_full          = (count == CNT_W'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        can_push         = (state == ST_RUN) & (~is_full | pop);
        // Without compressed support a PC with bit 1 set cannot be fetched.
        misaligned_fetch = ~C_EXT & fetch_pc[1];
        is_compressed    = C_EXT & (imem_rdata[1:0] != 2'b11);
        push_instr       = '0;
        if (!misaligned_fetch) begin
            push_instr = is_compressed ? {16'h0000, imem_rdata[15:0]} : imem_rdata;
        end
        next_seq_pc      = fetch_pc + (is_compressed ? XLEN'(2) : XLEN'(4));
        redirect_target  = redirect_pc & ~XLEN'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_VECTOR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_comp[i]  <= 1'b0;
                q_mis[i]   <= 1'b0;
            end
        end else if (redirect_valid) begin
            // Redirect wins: any push/pop of this cycle is dropped with the queue.
            state    <= ST_RUN;
            fetch_pc <= redirect_target;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (can_push) begin
                q_instr[wr_ptr] <= push_instr;
                q_pc[wr_ptr]    <= fetch_pc;
                q_comp[wr_ptr]  <= ~misaligned_fetch & is_compressed;
                q_mis[wr_ptr]   <= misaligned_fetch;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                if (misaligned_fetch) begin
                    // Marker is emitted once; PC holds until a redirect.
                    state <= ST_HALTED;
                end else begin
                    fetch_pc <= next_seq_pc;
                end
            end
            count <= count + CNT_W'(can_push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
module tb_instruction_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV_B  = 32'h0000_0040;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
        logic        mis;
    } ent_t;

    typedef struct {
        logic        valid;
        logic [31:0] addr;
    } st_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // DUT A: C_EXT=1, depth 4, reset vector 0
    logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc;
    logic        redirect_valid, out_valid, out_ready, out_compressed, out_misaligned;

    // DUT B: C_EXT=0, depth 2, reset vector 0x40
    logic [31:0] b_imem_addr, b_imem_rdata, b_redirect_pc, b_out_instr, b_out_pc;
    logic        b_redirect_valid, b_out_valid, b_out_ready, b_out_compressed, b_out_misaligned;

    // Byte-addressed instruction memory, address masked to 256 bytes.
    logic [7:0] mem [256];

    function automatic logic [31:0] win(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    assign imem_rdata   = win(imem_addr);
    assign b_imem_rdata = win(b_imem_addr);

    instruction_fetch_buffer #(
        .XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(DEPTH), .C_EXT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_compressed(out_compressed), .out_misaligned(out_misaligned)
    );

    instruction_fetch_buffer #(
        .XLEN(32), .RESET_VECTOR(RV_B), .FIFO_DEPTH(2), .C_EXT(1'b0)
    ) dut_b (
        .clk(clk), .reset(reset), .imem_addr(b_imem_addr), .imem_rdata(b_imem_rdata),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_compressed(b_out_compressed), .out_misaligned(b_out_misaligned)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of DUT A: fetch PC plus an ordered list of queued entries.
    logic [31:0] m_pc = 32'h0;
    logic        m_halted = 1'b0;
    ent_t        mq[$];
    ent_t        sb[$];
    st_t         stq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of DUT A: drive inputs, record expected status and handshake,
    // then apply the fetch rules for the coming edge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic [31:0] w;
        st_t         s;
        @(negedge clk);
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        s.valid = (mq.size() != 0);
        s.addr  = m_pc;
        stq.push_back(s);
        if (mq.size() != 0 && rdy) begin
            sb.push_back(mq[0]);
            mq.delete(0);
        end
        if (rv) begin
            mq.delete();
            m_pc     = rpc & 32'hFFFF_FFFE;
            m_halted = 1'b0;
        end else if (!m_halted && mq.size() < DEPTH) begin
            w = win(m_pc);
            if (w[1:0] != 2'b11) begin
                mq.push_back('{m_pc, {16'h0000, w[15:0]}, 1'b1, 1'b0});
                m_pc = m_pc + 32'd2;
            end else begin
                mq.push_back('{m_pc, w, 1'b0, 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Head check of DUT A at the current cycle (call right after step).
    task automatic expect_head(input logic [31:0] pc, input logic [31:0] instr, input logic c);
        #1;
        chk("head_valid", out_valid, 1'b1);
        chk("head_pc", out_pc, pc);
        chk("head_instr", out_instr, instr);
        chk("head_compressed", out_compressed, c);
        chk("head_misaligned", out_misaligned, 1'b0);
    endtask

    task automatic do_reset_mid();
        st_t s;
        @(negedge clk);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        s.valid = (mq.size() != 0);
        s.addr  = m_pc;
        stq.push_back(s);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_addr", imem_addr, 32'h0);
        mq.delete();
        m_pc     = 32'h0;
        m_halted = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic b_step(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        b_redirect_valid = rv;
        b_redirect_pc    = rpc;
        b_out_ready      = rdy;
        #1;
    endtask

    task automatic b_head(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
        chk("b_head_valid", b_out_valid, 1'b1);
        chk("b_head_pc", b_out_pc, pc);
        chk("b_head_instr", b_out_instr, instr);
        chk("b_head_compressed", b_out_compressed, 1'b0);
        chk("b_head_misaligned", b_out_misaligned, mis);
    endtask

    // Monitor: per-cycle status and in-order handshake comparison for DUT A.
    initial begin
        st_t  s;
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (stq.size() != 0) begin
                s = stq.pop_front();
                chk("out_valid", out_valid, s.valid);
                chk("imem_addr", imem_addr, s.addr);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_handshake: got pc %0h, expected no output", out_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_pc", out_pc, e.pc);
                        chk("sb_instr", out_instr, e.instr);
                        chk("sb_compressed", out_compressed, e.c);
                        chk("sb_misaligned", out_misaligned, e.mis);
                    end
                end
            end
        end
    end

    initial begin
        logic        rv, rdy;
        logic [31:0] rpc;

        redirect_valid   = 1'b0; redirect_pc   = '0; out_ready   = 1'b0;
        b_redirect_valid = 1'b0; b_redirect_pc = '0; b_out_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        // 0x00000013, 0x00100093, c.li 0x4501, 0x00000013
        mem[0]  = 8'h13; mem[1]  = 8'h00; mem[2]  = 8'h00; mem[3]  = 8'h00;
        mem[4]  = 8'h93; mem[5]  = 8'h00; mem[6]  = 8'h10; mem[7]  = 8'h00;
        mem[8]  = 8'h01; mem[9]  = 8'h45;
        mem[10] = 8'h13; mem[11] = 8'h00; mem[12] = 8'h00; mem[13] = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_pc", out_pc, 32'h0);
        chk("reset_compressed", out_compressed, 1'b0);
        chk("reset_misaligned", out_misaligned, 1'b0);
        chk("reset_addr", imem_addr, 32'h0);
        chk("b_reset_addr", b_imem_addr, RV_B);
        chk("b_reset_valid", b_out_valid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Straight-line code, then a compressed instruction followed by a 32-bit one.
        step(0, 0, 1);
        step(0, 0, 1); expect_head(32'h0, 32'h0000_0013, 1'b0);
        step(0, 0, 1); expect_head(32'h4, 32'h0010_0093, 1'b0);
        step(0, 0, 1); expect_head(32'h8, 32'h0000_4501, 1'b1);
        chk("addr_after_c", imem_addr, 32'ha);
        step(0, 0, 1); expect_head(32'ha, 32'h0000_0013, 1'b0);
        chk("addr_after_32", imem_addr, 32'he);

        // Back-pressure until full, then redirect while full with a pop.
        repeat (6) step(0, 0, 0);
        step(1, 32'h102, 1);
        step(0, 0, 1);
        #1;
        chk("redir_valid", out_valid, 1'b0);
        chk("redir_addr", imem_addr, 32'h102);
        step(0, 0, 1);
        #1;
        chk("redir_head_valid", out_valid, 1'b1);
        chk("redir_head_pc", out_pc, 32'h102);

        // PC wrap at the top of the address space, odd redirect target.
        step(1, 32'hFFFF_FFFC, 1);
        repeat (6) step(0, 0, 1);
        step(1, 32'h0000_0031, 0);
        repeat (4) step(0, 0, 1);

        // Randomised traffic with an asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset_mid();
            end else begin
                rv  = ($urandom_range(15) == 0);
                rpc = ($urandom_range(1) == 0) ? $urandom : 32'($urandom_range(511));
                rdy = ($urandom_range(9) < 7) && ((i % 200) >= 8);
                step(rv, rpc, rdy);
            end
        end
        step(0, 0, 0);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        // DUT B: C_EXT=0, misaligned marker and halt.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("b_async_reset_addr", b_imem_addr, RV_B);
        chk("b_async_reset_valid", b_out_valid, 1'b0);
        chk("b_async_reset_pc", b_out_pc, 32'h0);
        chk("b_async_reset_instr", b_out_instr, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        b_step(0, 0, 1);
        chk("b_first_valid", b_out_valid, 1'b0);
        chk("b_first_addr", b_imem_addr, RV_B);
        b_step(0, 0, 1);          b_head(RV_B, win(RV_B), 1'b0);
        b_step(1, 32'h6, 1);      b_head(RV_B + 32'd4, win(RV_B + 32'd4), 1'b0);
        b_step(0, 0, 1);
        chk("b_redir_valid", b_out_valid, 1'b0);
        chk("b_redir_addr", b_imem_addr, 32'h6);
        b_step(0, 0, 1);          b_head(32'h6, 32'h0, 1'b1);
        chk("b_mis_addr", b_imem_addr, 32'h6);
        for (int k = 0; k < 3; k++) begin
            b_step(0, 0, 1);
            chk("b_halt_valid", b_out_valid, 1'b0);
            chk("b_halt_addr", b_imem_addr, 32'h6);
        end
        b_step(1, 32'h8, 0);
        chk("b_halt_valid2", b_out_valid, 1'b0);
        b_step(0, 0, 1);
        chk("b_restart_addr", b_imem_addr, 32'h8);
        chk("b_restart_valid", b_out_valid, 1'b0);
        b_step(0, 0, 1);          b_head(32'h8, win(32'h8), 1'b0);
        b_step(0, 0, 0);          b_head(32'hc, win(32'hc), 1'b0);
        chk("b_bp_addr0", b_imem_addr, 32'h10);
        b_step(0, 0, 0);
        chk("b_bp_addr1", b_imem_addr, 32'h14);
        b_step(0, 0, 0);          b_head(32'hc, win(32'hc), 1'b0);
        chk("b_full_addr", b_imem_addr, 32'h14);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
